// File: rtl/tour_cmd.sv
// Command source mux: UART commands in IDLE, knight's-tour commands otherwise.
// Each one-hot knight move becomes a vertical then a horizontal move command.
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    state_t      state, nxt;
    logic [4:0]  idx, idx_nxt, look;
    logic [15:0] cmd_q, cmd_nxt, cmd_o;
    logic        err, err_nxt;
    logic        clr_q, clr_edge;
    logic        rdy_o, clr_uart_o;
    logic        legal;
    logic        dx_neg, dy_neg;
    logic [1:0]  dx_mag, dy_mag;
    logic [15:0] vcmd, hcmd;

    // A held clr_cmd_rdy level must only advance once.
    assign clr_edge = clr_cmd_rdy & ~clr_q;

    // Index presented to the move memory: looks ahead on the cycle a
    // new vertical command is registered.
    always_comb begin
        look = idx;
        if (state == IDLE && start_tour)
            look = 5'd0;
        else if (state == HOLD_H && send_resp && idx != LAST)
            look = idx + 5'd1;
    end

    always_comb begin
        legal  = 1'b1;
        dx_neg = 1'b0;
        dx_mag = 2'd0;
        dy_neg = 1'b0;
        dy_mag = 2'd0;
        case (move)
            8'h01: begin dx_mag = 2'd1; dy_mag = 2'd2; end
            8'h02: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_mag = 2'd2; end
            8'h04: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_mag = 2'd1; end
            8'h08: begin
                dx_neg = 1'b1; dx_mag = 2'd2;
                dy_neg = 1'b1; dy_mag = 2'd1;
            end
            8'h10: begin
                dx_neg = 1'b1; dx_mag = 2'd1;
                dy_neg = 1'b1; dy_mag = 2'd2;
            end
            8'h20: begin dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
            8'h40: begin dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
            8'h80: begin dx_mag = 2'd2; dy_mag = 2'd1; end
            default: legal = 1'b0;
        endcase
        vcmd = {4'h2, (dy_neg ? 8'h7F : 8'h00), 2'b00, dy_mag};
        hcmd = {4'h3, (dx_neg ? 8'h3F : 8'hBF), 2'b00, dx_mag};
    end

    always_comb begin
        nxt        = state;
        idx_nxt    = idx;
        cmd_nxt    = cmd_q;
        err_nxt    = err;
        cmd_o      = cmd_q;
        rdy_o      = 1'b0;
        clr_uart_o = 1'b0;
        resp       = 8'h5A;
        case (state)
            IDLE: begin
                cmd_o      = cmd_UART;
                rdy_o      = cmd_rdy_UART;
                clr_uart_o = clr_cmd_rdy;
                resp       = err ? 8'hEE : 8'hA5;
                if (cmd_rdy_UART && clr_cmd_rdy)
                    err_nxt = 1'b0;
                if (start_tour) begin
                    idx_nxt = 5'd0;
                    err_nxt = 1'b0;
                    if (legal) begin
                        cmd_nxt = vcmd;
                        nxt     = VERT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            VERT: begin
                rdy_o = 1'b1;
                if (clr_edge)
                    nxt = HOLD_V;
            end
            HOLD_V: begin
                if (send_resp) begin
                    cmd_nxt = hcmd;
                    nxt     = HORZ;
                end
            end
            HORZ: begin
                rdy_o = 1'b1;
                if (clr_edge)
                    nxt = HOLD_H;
            end
            HOLD_H: begin
                if (send_resp) begin
                    if (idx == LAST) begin
                        resp = 8'hA5;
                        nxt  = IDLE;
                    end else begin
                        idx_nxt = look;
                        if (legal) begin
                            cmd_nxt = vcmd;
                            nxt     = VERT;
                        end else begin
                            err_nxt = 1'b1;
                            nxt     = IDLE;
                        end
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 5'd0;
            cmd_q <= 16'h0000;
            err   <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            state <= nxt;
            idx   <= idx_nxt;
            cmd_q <= cmd_nxt;
            err   <= err_nxt;
            clr_q <= clr_cmd_rdy;
        end
    end

    assign mv_indx          = look;
    assign cmd              = cmd_o;
    assign cmd_rdy          = rst_n & rdy_o;
    assign clr_cmd_rdy_UART = rst_n & clr_uart_o;

endmodule

// File: tb/tb_tour_cmd.sv
// Directed testbench for tour_cmd: UART pass-through, move decode,
// full 24-move tour, illegal moves and handshake robustness.
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;

    logic [7:0]  mem [32];
    int nvec = 0;
    int nerr = 0;

    // Expected commands for one-hot bit k: vertical, then horizontal.
    logic [15:0] vexp [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                              16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
    logic [15:0] hexp [8] = '{16'h3BF1, 16'h33F1, 16'h33F2, 16'h33F2,
                              16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

    assign move = mem[mv_indx];

    always #10 clk = ~clk;

    tour_cmd #(.NUM_MOVES(24)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_send();
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b1;
        #5;
        nvec++;
        if (cmd_rdy !== 1'b0 || clr_cmd_rdy_UART !== 1'b0) begin
            nerr++;
            $display("FAIL reset_hs: rdy=%b clr_uart=%b want 0 0",
                     cmd_rdy, clr_cmd_rdy_UART);
        end
        nvec++;
        if (mv_indx !== 5'd0 || cmd !== 16'h0000 || resp !== 8'hA5) begin
            nerr++;
            $display("FAIL reset_val: idx=%0d cmd=%h resp=%h want 0 0000 a5",
                     mv_indx, cmd, resp);
        end
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_uart();
        cmd_UART     = 16'h2003;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b1;
        #1;
        nvec++;
        if (cmd !== 16'h2003 || cmd_rdy !== 1'b1 ||
            clr_cmd_rdy_UART !== 1'b1 || resp !== 8'hA5) begin
            nerr++;
            $display("FAIL uart_pass: cmd=%h rdy=%b clr=%b resp=%h want 2003 1 1 a5",
                     cmd, cmd_rdy, clr_cmd_rdy_UART, resp);
        end
        @(negedge clk);
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        cmd_UART     = 16'h0000;
        @(negedge clk);
    endtask

    task automatic test_first_move();
        do_reset();
        mem[0] = 8'h01;
        pulse_start();
        nvec++;
        if (cmd !== 16'h2002 || cmd_rdy !== 1'b1 || resp !== 8'h5A) begin
            nerr++;
            $display("FAIL first_vert: cmd=%h rdy=%b resp=%h want 2002 1 5a",
                     cmd, cmd_rdy, resp);
        end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        nvec++;
        if (cmd_rdy !== 1'b0 || cmd !== 16'h2002) begin
            nerr++;
            $display("FAIL first_holdv: rdy=%b cmd=%h want 0 2002", cmd_rdy, cmd);
        end
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        nvec++;
        if (cmd !== 16'h3BF1 || cmd_rdy !== 1'b1) begin
            nerr++;
            $display("FAIL first_horz: cmd=%h rdy=%b want 3bf1 1", cmd, cmd_rdy);
        end
        pulse_clr();
        nvec++;
        if (cmd_rdy !== 1'b0 || cmd !== 16'h3BF1) begin
            nerr++;
            $display("FAIL first_holdh: rdy=%b cmd=%h want 0 3bf1", cmd_rdy, cmd);
        end
    endtask

    task automatic test_decode();
        logic [7:0]  mv [3];
        logic [15:0] ev [3];
        logic [15:0] eh [3];
        mv = '{8'h08, 8'h80, 8'h10};
        ev = '{16'h27F1, 16'h2001, 16'h27F2};
        eh = '{16'h33F2, 16'h3BF2, 16'h33F1};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            mem[0] = mv[i];
            pulse_start();
            nvec++;
            if (cmd !== ev[i] || cmd_rdy !== 1'b1) begin
                nerr++;
                $display("FAIL decode_v[%0h]: cmd=%h rdy=%b want %h 1",
                         mv[i], cmd, cmd_rdy, ev[i]);
            end
            pulse_clr();
            pulse_send();
            nvec++;
            if (cmd !== eh[i] || cmd_rdy !== 1'b1) begin
                nerr++;
                $display("FAIL decode_h[%0h]: cmd=%h rdy=%b want %h 1",
                         mv[i], cmd, cmd_rdy, eh[i]);
            end
        end
    endtask

    task automatic test_full_tour();
        logic [7:0] er;
        do_reset();
        for (int k = 0; k < 24; k++)
            mem[k] = 8'(1 << (k % 8));
        pulse_start();
        for (int k = 0; k < 24; k++) begin
            nvec++;
            if (cmd_rdy !== 1'b1 || cmd !== vexp[k % 8] || mv_indx !== 5'(k)) begin
                nerr++;
                $display("FAIL tour_vert[%0d]: rdy=%b cmd=%h idx=%0d want 1 %h %0d",
                         k, cmd_rdy, cmd, mv_indx, vexp[k % 8], k);
            end
            pulse_clr();
            repeat (18) @(negedge clk);
            send_resp = 1'b1;
            #1;
            nvec++;
            if (resp !== 8'h5A) begin
                nerr++;
                $display("FAIL tour_resp_v[%0d]: resp=%h want 5a", k, resp);
            end
            @(negedge clk);
            send_resp = 1'b0;
            nvec++;
            if (cmd_rdy !== 1'b1 || cmd !== hexp[k % 8]) begin
                nerr++;
                $display("FAIL tour_horz[%0d]: rdy=%b cmd=%h want 1 %h",
                         k, cmd_rdy, cmd, hexp[k % 8]);
            end
            pulse_clr();
            repeat (18) @(negedge clk);
            send_resp = 1'b1;
            #1;
            er = (k == 23) ? 8'hA5 : 8'h5A;
            nvec++;
            if (resp !== er) begin
                nerr++;
                $display("FAIL tour_resp_h[%0d]: resp=%h want %h", k, resp, er);
            end
            @(negedge clk);
            send_resp = 1'b0;
        end
        cmd_UART = 16'h1234;
        #1;
        nvec++;
        if (cmd !== 16'h1234 || cmd_rdy !== 1'b0 || resp !== 8'hA5 ||
            mv_indx !== 5'd23) begin
            nerr++;
            $display("FAIL tour_end: cmd=%h rdy=%b resp=%h idx=%0d want 1234 0 a5 23",
                     cmd, cmd_rdy, resp, mv_indx);
        end
        cmd_UART = 16'h0000;
    endtask

    task automatic test_illegal();
        do_reset();
        for (int k = 0; k < 5; k++)
            mem[k] = 8'h01;
        mem[5] = 8'h03;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            pulse_clr();
            pulse_send();
            pulse_clr();
            if (k < 4)
                pulse_send();
        end
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        nvec++;
        if (cmd_rdy !== 1'b0 || resp !== 8'hEE || mv_indx !== 5'd5) begin
            nerr++;
            $display("FAIL illegal_03: rdy=%b resp=%h idx=%0d want 0 ee 5",
                     cmd_rdy, resp, mv_indx);
        end
        cmd_rdy_UART = 1'b1;
        #1;
        nvec++;
        if (cmd_rdy !== 1'b1) begin
            nerr++;
            $display("FAIL illegal_uart: rdy=%b want 1", cmd_rdy);
        end
        cmd_rdy_UART = 1'b0;
        @(negedge clk);
        mem[0] = 8'h00;
        pulse_start();
        nvec++;
        if (cmd_rdy !== 1'b0 || resp !== 8'hEE || mv_indx !== 5'd0) begin
            nerr++;
            $display("FAIL illegal_00: rdy=%b resp=%h idx=%0d want 0 ee 0",
                     cmd_rdy, resp, mv_indx);
        end
    endtask

    task automatic test_robust();
        do_reset();
        mem[0] = 8'h01;
        pulse_start();
        clr_cmd_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            nvec++;
            if (cmd_rdy !== 1'b0 || cmd !== 16'h2002) begin
                nerr++;
                $display("FAIL clr_hold[%0d]: rdy=%b cmd=%h want 0 2002",
                         i, cmd_rdy, cmd);
            end
        end
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        nvec++;
        if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0 || resp !== 8'h5A) begin
            nerr++;
            $display("FAIL start_in_hold: rdy=%b idx=%0d resp=%h want 0 0 5a",
                     cmd_rdy, mv_indx, resp);
        end
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        nvec++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h3BF1) begin
            nerr++;
            $display("FAIL send_with_clr: rdy=%b cmd=%h want 1 3bf1", cmd_rdy, cmd);
        end
        @(negedge clk);
        nvec++;
        if (cmd_rdy !== 1'b1) begin
            nerr++;
            $display("FAIL clr_level_horz: rdy=%b want 1", cmd_rdy);
        end
        cmd_rdy_UART = 1'b1;
        cmd_UART     = 16'h2003;
        #1;
        nvec++;
        if (clr_cmd_rdy_UART !== 1'b0 || cmd !== 16'h3BF1) begin
            nerr++;
            $display("FAIL uart_iso: clr_uart=%b cmd=%h want 0 3bf1",
                     clr_cmd_rdy_UART, cmd);
        end
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        nvec++;
        if (cmd_rdy !== 1'b0 || clr_cmd_rdy_UART !== 1'b0) begin
            nerr++;
            $display("FAIL horz_adv: rdy=%b clr_uart=%b want 0 0",
                     cmd_rdy, clr_cmd_rdy_UART);
        end
        cmd_UART = 16'h0000;
        rst_n    = 1'b0;
        #1;
        nvec++;
        if (mv_indx !== 5'd0 || cmd !== 16'h0000 || cmd_rdy !== 1'b0 ||
            resp !== 8'hA5) begin
            nerr++;
            $display("FAIL reset_mid: idx=%0d cmd=%h rdy=%b resp=%h want 0 0000 0 a5",
                     mv_indx, cmd, cmd_rdy, resp);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        clr_cmd_rdy = 1'b1;
        #1;
        nvec++;
        if (cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b1) begin
            nerr++;
            $display("FAIL uart_restore: rdy=%b clr_uart=%b want 1 1",
                     cmd_rdy, clr_cmd_rdy_UART);
        end
        @(negedge clk);
        clr_cmd_rdy  = 1'b0;
        cmd_rdy_UART = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = 8'h00;
        test_reset();
        test_uart();
        test_first_move();
        test_decode();
        test_full_tour();
        test_illegal();
        test_robust();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
